// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-word bit positions, funct3 access-size
// encodings and the memory-stage state type.
package pipe_pkg;

    // Control-word bit positions
    localparam int CTL_MEM_TO_REG = 20;  // load result goes to rd (also marks a load)
    localparam int CTL_RA_TO_REG  = 19;  // link address goes to rd
    localparam int CTL_MEM_WRITE  = 18;  // store
    localparam int CTL_REG_WRITE  = 16;  // rd is written

    // funct3 access-size encodings (ir[14:12])
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic for the memory stage.
// Request side: legality/alignment check, store lane replication and strobes,
// all from the instruction currently in EX/MEM.
// Response side: load byte/halfword extraction and sign/zero extension, using
// the size and offset latched when the request was issued.
module mem_align
    import pipe_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    output logic        ok,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic        legal;
    logic        aligned;
    logic [31:0] shifted;

    // Legal size for the access direction, and natural alignment for that size
    always_comb begin
        legal   = 1'b0;
        aligned = 1'b1;
        if (is_store) begin
            legal = funct3 inside {F3_B, F3_H, F3_W};
        end else begin
            legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        end
        case (funct3)
            F3_H, F3_HU: aligned = ~offset[0];
            F3_W:        aligned = (offset == 2'b00);
            default:     aligned = 1'b1;
        endcase
        ok = legal & aligned;
    end

    // Store data is replicated across lanes so the strobes alone select the target bytes
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata[8*gi +: 8] = !is_store          ? 8'h00 :
                                      (funct3 == F3_B)   ? store_data[7:0] :
                                      (funct3 == F3_H)   ? store_data[8*(gi%2) +: 8] :
                                                           store_data[8*gi +: 8];
        end
    endgenerate

    // Byte strobes shifted to the addressed lane; loads never write
    always_comb begin
        wstrb = 4'b0000;
        if (is_store) begin
            case (funct3)
                F3_B:    wstrb = 4'b0001 << offset;
                F3_H:    wstrb = 4'b0011 << offset;
                F3_W:    wstrb = 4'b1111;
                default: wstrb = 4'b0000;
            endcase
        end
    end

    assign shifted = rdata >> {ld_offset, 3'b000};

    // Extract the addressed byte/halfword and extend to 32 bits
    always_comb begin
        case (ld_funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    load_data = rdata;
            F3_BU:   load_data = {24'h000000, shifted[7:0]};
            F3_HU:   load_data = {16'h0000, shifted[15:0]};
            default: load_data = 32'h00000000;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage of the RV32 pipeline. Owns the MEM/WB register, issues
// loads/stores over a req/ack handshake, stalls upstream while an access is
// outstanding, and abandons an access after TIMEOUT cycles without ack.
module mem_stage
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            valid_in,
    input  logic [31:0]     ir_in,
    input  logic [31:0]     ctl_in,
    input  logic [XLEN-1:0] ra_in,
    input  logic [XLEN-1:0] alu_y_in,
    input  logic [XLEN-1:0] rs2_in,
    output logic            stall,
    output logic            dm_req,
    output logic            dm_we,
    output logic [XLEN-1:0] dm_addr,
    output logic [XLEN-1:0] dm_wdata,
    output logic [3:0]      dm_wstrb,
    input  logic            dm_ack,
    input  logic [XLEN-1:0] dm_rdata,
    output logic            valid_wb,
    output logic [31:0]     ir_wb,
    output logic [31:0]     ctl_wb,
    output logic [XLEN-1:0] ra_wb,
    output logic [XLEN-1:0] rdata_wb,
    output logic [XLEN-1:0] alu_y_wb,
    output logic            misalign,
    output logic            bus_err
);

    localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    mem_state_t  state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]  ld_funct3_reg;
    logic [1:0]  ld_offset_reg;

    logic        mem_op;
    logic        is_store;
    logic        ok;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] load_data;

    assign mem_op   = valid_in & (ctl_in[CTL_MEM_TO_REG] | ctl_in[CTL_MEM_WRITE]);
    assign is_store = ctl_in[CTL_MEM_WRITE];

    mem_align u_align (
        .funct3     (ir_in[14:12]),
        .is_store   (is_store),
        .offset     (alu_y_in[1:0]),
        .store_data (rs2_in),
        .ok         (ok),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .ld_funct3  (ld_funct3_reg),
        .ld_offset  (ld_offset_reg),
        .rdata      (dm_rdata),
        .load_data  (load_data)
    );

    // Hold EX/MEM while a legal access is being issued or awaits its ack;
    // released on the ack or the final timeout cycle, and forced low in reset
    always_comb begin
        stall = 1'b0;
        if (rstn) begin
            if (state_reg == IDLE) begin
                stall = mem_op & ok;
            end else begin
                stall = !dm_ack && (cnt_reg != CNT_LAST);
            end
        end
    end

    // Access FSM with request outputs and the MEM/WB register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            ld_funct3_reg <= 3'b000;
            ld_offset_reg <= 2'b00;
            dm_req        <= 1'b0;
            dm_we         <= 1'b0;
            dm_addr       <= '0;
            dm_wdata      <= '0;
            dm_wstrb      <= 4'b0000;
            valid_wb      <= 1'b0;
            ir_wb         <= '0;
            ctl_wb        <= '0;
            ra_wb         <= '0;
            rdata_wb      <= '0;
            alu_y_wb      <= '0;
            misalign      <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (mem_op && ok) begin
                        dm_req        <= 1'b1;
                        dm_we         <= is_store;
                        dm_addr       <= {alu_y_in[XLEN-1:2], 2'b00};
                        dm_wdata      <= wdata;
                        dm_wstrb      <= wstrb;
                        ld_funct3_reg <= ir_in[14:12];
                        ld_offset_reg <= alu_y_in[1:0];
                        cnt_reg       <= '0;
                        state_reg     <= WAIT;
                        // MEM/WB contents are kept; only valid drops so the
                        // previous instruction is not retired a second time
                        valid_wb      <= 1'b0;
                    end else begin
                        misalign <= mem_op;
                        valid_wb <= valid_in & !mem_op;
                        ctl_wb   <= (valid_in && !mem_op) ? ctl_in : 32'h0;
                        ir_wb    <= ir_in;
                        ra_wb    <= ra_in;
                        alu_y_wb <= alu_y_in;
                        rdata_wb <= '0;
                    end
                end
                WAIT: begin
                    if (dm_ack) begin
                        dm_req    <= 1'b0;
                        state_reg <= IDLE;
                        valid_wb  <= 1'b1;
                        ctl_wb    <= ctl_in;
                        ir_wb     <= ir_in;
                        ra_wb     <= ra_in;
                        alu_y_wb  <= alu_y_in;
                        rdata_wb  <= dm_we ? '0 : load_data;
                    end else if (cnt_reg == CNT_LAST) begin
                        dm_req    <= 1'b0;
                        bus_err   <= 1'b1;
                        state_reg <= IDLE;
                        valid_wb  <= 1'b0;
                        ctl_wb    <= '0;
                        rdata_wb  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage. The driver computes each
// instruction's expected outcome from a byte-level memory model and pushes it;
// a memory responder and a WB monitor pop and compare independently.
module tb_mem_stage;

    localparam int TO = 4;
    localparam int EV_WB = 0, EV_MIS = 1, EV_BERR = 2;

    typedef struct {
        int          kind;
        logic [31:0] ir, ctl, ra, alu_y, rdata;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr, wdata;
        logic [3:0]  wstrb;
        logic        we;
        int          delay;
    } req_exp_t;

    logic        clk, rstn, valid_in, stall, dm_req, dm_we, dm_ack;
    logic [31:0] ir_in, ctl_in, ra_in, alu_y_in, rs2_in;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_wstrb;
    logic        valid_wb, misalign, bus_err;
    logic [31:0] ir_wb, ctl_wb, ra_wb, rdata_wb, alu_y_wb;

    wb_exp_t     exp_q[$];
    req_exp_t    req_q[$];
    logic [31:0] ref_mem[8];
    logic [31:0] rsp_mem[8];
    int          n_tests = 0;
    int          n_fail  = 0;

    mem_stage #(.TIMEOUT(TO), .XLEN(32)) dut (
        .clk(clk), .rstn(rstn), .valid_in(valid_in), .ir_in(ir_in), .ctl_in(ctl_in),
        .ra_in(ra_in), .alu_y_in(alu_y_in), .rs2_in(rs2_in), .stall(stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wstrb(dm_wstrb), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .valid_wb(valid_wb),
        .ir_wb(ir_wb), .ctl_wb(ctl_wb), .ra_wb(ra_wb), .rdata_wb(rdata_wb),
        .alu_y_wb(alu_y_wb), .misalign(misalign), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] load_val(logic [31:0] word, int o, int size, bit sgn);
        longint v;
        v = longint'(word >> (8*o)) & ((64'd1 << (8*size)) - 1);
        if (sgn && size < 4 && v >= (64'd1 << (8*size - 1))) v = v - (64'd1 << (8*size));
        return v[31:0];
    endfunction

    task automatic preload(input int idx, input logic [31:0] w);
        ref_mem[idx] = w;
        rsp_mem[idx] = w;
    endtask

    // kind: 0 = ALU op, 1 = load, 2 = store
    task automatic issue(input bit v, input int kind, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2, input int delay);
        logic [31:0] ir, ctl, ra;
        wb_exp_t     e;
        req_exp_t    r;
        int          o, size, idx, exp_stall, nst;
        bit          legal, memop;
        ir = $urandom; ir[14:12] = f3;
        ctl = $urandom;
        ctl[20] = (kind == 1);
        ctl[18] = (kind == 2);
        if (kind == 0) ctl[16] = 1'b1;
        ra = $urandom;
        o = int'(addr[1:0]);
        idx = int'(addr[4:2]);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        memop = v && (kind != 0);
        legal = (kind == 2) ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        legal = legal && (o % size == 0);
        e.ir = ir; e.ctl = ctl; e.ra = ra; e.alu_y = addr; e.rdata = 32'h0;
        exp_stall = 0;
        if (!v) begin
            // bubble: nothing retires
        end else if (!memop) begin
            e.kind = EV_WB; exp_q.push_back(e);
        end else if (!legal) begin
            e.kind = EV_MIS; exp_q.push_back(e);
        end else begin
            r.addr = addr & 32'hFFFF_FFFC; r.we = (kind == 2); r.delay = delay;
            r.wstrb = 4'b0000; r.wdata = 32'h0;
            if (kind == 2) begin
                for (int j = 0; j < 4; j++) r.wdata[8*j +: 8] = rs2[8*(j % size) +: 8];
                for (int k = 0; k < size; k++) r.wstrb[o+k] = 1'b1;
            end
            req_q.push_back(r);
            if (delay < TO) begin
                e.kind = EV_WB;
                if (kind == 2) begin
                    for (int k = 0; k < size; k++) ref_mem[idx][8*(o+k) +: 8] = rs2[8*k +: 8];
                end else begin
                    e.rdata = load_val(ref_mem[idx], o, size, f3[2] == 1'b0);
                end
                exp_stall = delay + 1;
            end else begin
                e.kind = EV_BERR;
                exp_stall = TO;
            end
            exp_q.push_back(e);
        end
        valid_in = v; ir_in = ir; ctl_in = ctl; ra_in = ra; alu_y_in = addr; rs2_in = rs2;
        nst = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (stall) nst++;
            else break;
        end
        check("stall_cycles", nst, exp_stall);
        $display("[TB] v=%0d kind=%0d f3=%0d addr=%h rs2=%h delay=%0d stalls=%0d",
                 v, kind, f3, addr, rs2, delay, nst);
        @(posedge clk); #1;
    endtask

    // Data-memory responder: checks each new request and acks after its delay
    int  rsp_cnt = 0;
    int  rsp_delay = 0;
    bit  rsp_busy = 0;
    always begin
        @(posedge clk); #1;
        dm_ack = 1'b0;
        dm_rdata = $urandom;
        if (!rstn || !dm_req) begin
            rsp_busy = 0;
        end else begin
            if (!rsp_busy) begin
                rsp_busy = 1; rsp_cnt = 0;
                if (req_q.size() == 0) begin
                    check("unexpected_req", dm_req, 1'b0);
                    rsp_delay = 0;
                end else begin
                    req_exp_t r;
                    r = req_q.pop_front();
                    rsp_delay = r.delay;
                    check("dm_addr", dm_addr, r.addr);
                    check("dm_we", dm_we, r.we);
                    check("dm_wstrb", dm_wstrb, r.wstrb);
                    if (r.we) check("dm_wdata", dm_wdata, r.wdata);
                end
            end else begin
                rsp_cnt++;
            end
            if (rsp_cnt == rsp_delay) begin
                dm_ack = 1'b1;
                if (dm_we) begin
                    for (int j = 0; j < 4; j++)
                        if (dm_wstrb[j]) rsp_mem[dm_addr[4:2]][8*j +: 8] = dm_wdata[8*j +: 8];
                end else begin
                    dm_rdata = rsp_mem[dm_addr[4:2]];
                end
            end
        end
    end

    // WB monitor: every retirement/error pulse consumes one expectation
    always @(negedge clk) begin
        if (rstn) begin
            if (misalign || bus_err || valid_wb) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {misalign, bus_err, valid_wb}, 3'b000);
                end else begin
                    wb_exp_t e;
                    e = exp_q.pop_front();
                    check("event_kind", valid_wb ? EV_WB : misalign ? EV_MIS : EV_BERR, e.kind);
                    check("event_single", 32'(misalign) + 32'(bus_err) + 32'(valid_wb), 1);
                    if (valid_wb) begin
                        check("ir_wb", ir_wb, e.ir);
                        check("ctl_wb", ctl_wb, e.ctl);
                        check("ra_wb", ra_wb, e.ra);
                        check("alu_y_wb", alu_y_wb, e.alu_y);
                        check("rdata_wb", rdata_wb, e.rdata);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; valid_in = 1'b0; ir_in = 0; ctl_in = 0; ra_in = 0;
        alu_y_in = 0; rs2_in = 0; dm_ack = 1'b0; dm_rdata = 0;
        for (int i = 0; i < 8; i++) preload(i, $urandom);
        repeat (3) @(negedge clk);
        check("rst_dm_req", dm_req, 0);   check("rst_dm_we", dm_we, 0);
        check("rst_dm_addr", dm_addr, 0); check("rst_dm_wdata", dm_wdata, 0);
        check("rst_dm_wstrb", dm_wstrb, 0); check("rst_valid_wb", valid_wb, 0);
        check("rst_ir_wb", ir_wb, 0);     check("rst_ctl_wb", ctl_wb, 0);
        check("rst_ra_wb", ra_wb, 0);     check("rst_rdata_wb", rdata_wb, 0);
        check("rst_alu_y_wb", alu_y_wb, 0); check("rst_misalign", misalign, 0);
        check("rst_bus_err", bus_err, 0); check("rst_stall", stall, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        issue(1, 0, 3'b000, 32'h0000_1234, 32'h0, 0);           // ALU op
        issue(1, 2, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 2);   // SB, ack 3 cycles after issue
        preload(0, 32'h0000_8000);
        issue(1, 1, 3'b000, 32'h0000_2001, 32'h0, 0);           // LB -> FFFFFF80
        issue(1, 1, 3'b100, 32'h0000_2001, 32'h0, 0);           // LBU -> 00000080
        issue(1, 1, 3'b010, 32'h0000_2002, 32'h0, 0);           // LW misaligned
        issue(1, 1, 3'b001, 32'h0000_2003, 32'h0, 0);           // LH misaligned
        issue(1, 1, 3'b010, 32'h0000_2004, 32'h0, 9);           // no ack -> timeout
        issue(1, 1, 3'b010, 32'h0000_2004, 32'h0, TO - 1);      // ack on final cycle
        issue(1, 2, 3'b011, 32'h0000_2008, 32'h1234_5678, 0);   // illegal store size
        issue(0, 1, 3'b010, 32'h0000_2008, 32'h0, 0);           // bubble with mem bits

        // Reset while an access is outstanding
        begin
            req_exp_t r;
            r.addr = 32'h0000_2010; r.we = 1'b0; r.wstrb = 4'b0000; r.wdata = 0; r.delay = 99;
            req_q.push_back(r);
            valid_in = 1'b1; ir_in = 32'h0000_2003; ctl_in = 32'h0010_0000;
            alu_y_in = 32'h0000_2010;
            @(posedge clk); @(posedge clk); #3;
            rstn = 1'b0;
            #1;
            check("midrst_dm_req", dm_req, 0);
            check("midrst_valid_wb", valid_wb, 0);
            check("midrst_stall", stall, 0);
            valid_in = 1'b0;
            @(negedge clk); #1;
            rstn = 1'b1;
            @(posedge clk); #1;
            $display("[TB] reset during WAIT");
        end
        issue(1, 1, 3'b010, 32'h0000_2010, 32'h0, 1);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            bit          v;
            int          kind, delay;
            logic [2:0]  f3;
            logic [31:0] addr;
            v = ($urandom_range(0, 7) != 0);
            kind = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (kind == 2) f3 = 3'($urandom_range(0, 2));
            else begin
                int pick;
                pick = $urandom_range(0, 4);
                f3 = (pick < 3) ? 3'(pick) : 3'(pick + 1);
            end
            addr = 32'h0000_2000 + 32'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            delay = ($urandom_range(0, 9) < 8) ? $urandom_range(0, TO - 1) : TO;
            issue(v, kind, f3, addr, $urandom, delay);
        end

        valid_in = 1'b0;
        repeat (4) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("req_q_drained", req_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
